// File: rtl/divisor_peso.sv
// Sell-by-value divider: weight in grams = floor(precoAlvo*1000 / centimos).
// Restoring divider, one quotient bit per clock, with a start/busy/done handshake.
module divisor_peso #(
  parameter int QW = 12,
  parameter int DW = 29
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [18:0]   precoAlvo,
  input  logic [QW-1:0] centimos,
  output logic [QW-1:0] weightInGrams,
  output logic [QW-1:0] resto,
  output logic          busy,
  output logic          done,
  output logic          sat,
  output logic          divZero
);

  localparam int CW = $clog2(DW);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  typedef struct packed {
    logic [18:0]   preco;
    logic [QW-1:0] cent;
  } req_t;

  logic [1:0]    state;
  req_t          req;
  logic [DW-1:0] dvd;   // dividend on entry, quotient once all bits are shifted through
  logic [QW-1:0] rem;
  logic [CW-1:0] cnt;

  logic [DW-1:0] pe;
  logic [DW-1:0] x1000;
  logic [QW:0]   rsh;
  logic          ge;
  logic [QW:0]   rdif;
  logic [QW-1:0] rnext;
  logic          qovf;

  // *1000 as shifts and subtracts: 1024 - 16 - 8
  assign pe    = DW'(req.preco);
  assign x1000 = (pe << 10) - (pe << 4) - (pe << 3);

  // Partial remainder is always below the divisor, so the 13-bit step result fits back in QW bits.
  assign rsh   = {rem, dvd[DW-1]};
  assign ge    = rsh >= {1'b0, req.cent};
  assign rdif  = rsh - {1'b0, req.cent};
  assign rnext = ge ? rdif[QW-1:0] : rsh[QW-1:0];
  assign qovf  = |dvd[DW-1:QW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      req           <= '0;
      dvd           <= '0;
      rem           <= '0;
      cnt           <= '0;
      weightInGrams <= '0;
      resto         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sat           <= 1'b0;
      divZero       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            req   <= '{preco: precoAlvo, cent: centimos};
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          dvd   <= x1000;
          rem   <= '0;
          cnt   <= CW'(DW - 1);
          state <= (req.cent == '0) ? FINISH : DIV;
        end
        DIV: begin
          rem <= rnext;
          dvd <= {dvd[DW-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (req.cent == '0) begin
            weightInGrams <= '1;
            resto         <= '0;
            sat           <= 1'b0;
            divZero       <= 1'b1;
          end else if (qovf) begin
            weightInGrams <= '1;
            resto         <= '0;
            sat           <= 1'b1;
            divZero       <= 1'b0;
          end else begin
            weightInGrams <= dvd[QW-1:0];
            resto         <= rem;
            sat           <= 1'b0;
            divZero       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_peso.sv
// Scoreboard bench for divisor_peso: stimulus pushes model results, a negedge monitor checks each done.
module tb_divisor_peso;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [18:0] precoAlvo;
  logic [11:0] centimos;
  logic [11:0] weightInGrams;
  logic [11:0] resto;
  logic        busy, done, sat, divZero;

  divisor_peso dut (
    .clk(clk), .reset(reset), .start(start), .precoAlvo(precoAlvo), .centimos(centimos),
    .weightInGrams(weightInGrams), .resto(resto), .busy(busy), .done(done),
    .sat(sat), .divZero(divZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int r;
    int sat;
    int dz;
    int cyc;
    int lat;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic from the functional rules.
  function automatic exp_t model(input int p, input int c, input int at);
    exp_t   e;
    longint num, quo;
    num = longint'(p) * 1000;
    e.sat = 0; e.dz = 0;
    if (c == 0) begin
      e.w = 4095; e.r = 0; e.dz = 1; e.lat = 2;
    end else begin
      quo   = num / c;
      e.lat = 31;
      if (quo > 4095) begin
        e.w = 4095; e.r = 0; e.sat = 1;
      end else begin
        e.w = int'(quo); e.r = int'(num % c);
      end
    end
    e.cyc = at + e.lat;
    return e;
  endfunction

  // Monitor: result checks on done, output-hold checks otherwise.
  exp_t e_mon;
  int   bcnt = 0;
  int   lw = 0, lr = 0, ls = 0, ld = 0;
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0; lw = 0; lr = 0; ls = 0; ld = 0;
    end else if (done) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e_mon = q.pop_front();
        chk("weight", int'(weightInGrams), e_mon.w);
        chk("resto", int'(resto), e_mon.r);
        chk("sat", int'(sat), e_mon.sat);
        chk("divZero", int'(divZero), e_mon.dz);
        chk("done_cycle", cyc, e_mon.cyc);
        chk("busy_len", bcnt, e_mon.lat);
      end
      chk("busy_at_done", int'(busy), 0);
      chk("sat_dz_excl", int'(sat & divZero), 0);
      lw = weightInGrams; lr = resto; ls = sat; ld = divZero;
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      chk("hold_weight", int'(weightInGrams), lw);
      chk("hold_resto", int'(resto), lr);
      chk("hold_flags", int'({sat, divZero}), (ls << 1) | ld);
    end
  end

  task automatic to_cyc(input int x);
    do @(negedge clk); while (cyc < x);
  endtask

  task automatic issue(input int p, input int c);
    @(negedge clk);
    precoAlvo = 19'(p); centimos = 12'(c); start = 1'b1;
    q.push_back(model(p, c, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0) return;
    end
    n_chk++; n_fail++;
    $display("FAIL timeout: got %0d pending results, expected 0", q.size());
    q.delete();
  endtask

  int k, p, c;

  initial begin
    reset = 1'b1; start = 1'b0; precoAlvo = '0; centimos = '0;
    repeat (2) @(negedge clk);
    chk("rst_weight", int'(weightInGrams), 0);
    chk("rst_resto", int'(resto), 0);
    chk("rst_ctrl", int'({busy, done, sat, divZero}), 0);
    reset = 1'b0;

    // Directed cases
    issue(705, 470);    wait_idle();
    issue(100, 300);    wait_idle();
    issue(1, 4095);     wait_idle();
    issue(524287, 1);   wait_idle();
    issue(4095, 1000);  wait_idle();
    issue(500, 0);      wait_idle();

    // Start while busy is ignored; start during the done cycle waits one edge
    @(negedge clk);
    k = cyc;
    precoAlvo = 19'd705; centimos = 12'd470; start = 1'b1;
    q.push_back(model(705, 470, k + 1));
    @(negedge clk); start = 1'b0;
    to_cyc(k + 10);
    precoAlvo = 19'd1; centimos = 12'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    to_cyc(k + 31);
    precoAlvo = 19'd100; centimos = 12'd300; start = 1'b1;
    q.push_back(model(100, 300, k + 33));
    to_cyc(k + 33); start = 1'b0;
    wait_idle();

    // Start held high: back-to-back operations
    @(negedge clk);
    k = cyc;
    precoAlvo = 19'd2000; centimos = 12'd777; start = 1'b1;
    q.push_back(model(2000, 777, k + 1));
    q.push_back(model(2000, 777, k + 33));
    to_cyc(k + 33); start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-operation
    @(negedge clk);
    k = cyc;
    precoAlvo = 19'd705; centimos = 12'd470; start = 1'b1;
    q.push_back(model(705, 470, k + 1));
    @(negedge clk); start = 1'b0;
    to_cyc(k + 15);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async_weight", int'(weightInGrams), 0);
    chk("async_resto", int'(resto), 0);
    chk("async_ctrl", int'({busy, done, sat, divZero}), 0);
    q.delete(q.size() - 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    issue(100, 300); wait_idle();

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4095));
      if ($urandom_range(0, 1) == 1) p = int'($urandom_range(0, 524287));
      else p = int'($urandom_range(0, (c == 0 ? 1 : c) * 4));
      if (p > 524287) p = 524287;
      issue(p, c);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
